mem_bridge: RTL and testbench
=============================

Name: mem_bridge

Overview:
Parametrised successor of the core-to-SDRAM glue at the top level. Arbitrates NUM_READ core read channels (instruction/cache, data, ...) onto one memory read master. Buffers core writes in a posted write FIFO that drains to one memory write master, with read-after-write hazard protection. Per-channel enables replace the fixed switch gating: a disabled channel completes instantly with zero data.

Parameters:
NUM_READ, 2, number of read channels (index 0 highest initial priority)
ADDR_W, 25, byte address width
DATA_W, 32, data word width
WBUF_DEPTH, 4, write FIFO entries (power of 2, >=2)

Ports:
clock  in  1  sole clock, all logic on rising edge
reset  in  1  synchronous, active-high
rd_enable  in  NUM_READ  per-channel read request, held until rd_valid
rd_addr  in  NUM_READ x ADDR_W  per-channel byte address
rd_valid  out  NUM_READ  per-channel read completion
rd_data  out  NUM_READ x DATA_W  per-channel read data
rd_chan_on  in  NUM_READ  1 = channel uses memory; 0 = bypass (valid, zero data)
wr_enable  in  1  core write request
wr_addr  in  ADDR_W  write byte address
wr_data  in  DATA_W  write data
wr_valid  out  1  write accepted
wr_chan_on  in  1  1 = writes reach memory; 0 = discard, always accept
mem_read_n  out  1  memory read request, active-low
mem_read_address  out  ADDR_W  word-aligned, low 2 bits 0
mem_read_data  in  DATA_W  memory read data
mem_data_ready_n  in  1  read data valid, active-low
mem_write_n  out  1  memory write request, active-low
mem_write_address  out  ADDR_W  word-aligned, low 2 bits 0
mem_write_data  out  DATA_W  memory write data
mem_data_written_n  in  1  write done, active-low
wbuf_count  out  clog2(WBUF_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: FSM IDLE, rr pointer=NUM_READ-1 (channel 0 searched first), mem_read_n=1, mem_write_n=1, rd_valid (on channels)=0, rd_data=0, FIFO emptied (contents discarded), wbuf_count=0. Reset mid-transaction abandons it; a late memory handshake after reset is ignored.
- Address compare and memory addresses use bits [ADDR_W-1:2]; low 2 bits forced 0.
- Read FSM: IDLE -> READ -> RESP -> IDLE.
  - IDLE: candidates = rd_enable & rd_chan_on & ~hazard. Grant the first candidate after rr pointer, round-robin. Latch channel/address, rr pointer=grant. Next cycle READ with mem_read_n=0.
  - READ: hold mem_read_n=0 and address until mem_data_ready_n=0. Then latch mem_read_data, go RESP, and raise mem_read_n in the same edge.
  - RESP: rd_valid[grant]=1 for exactly one cycle with rd_data[grant]=latched data. Channel's rd_enable ignored this cycle. Next IDLE; enable still high there = new request.
  - Minimum latency enable->valid: 3 cycles when mem_data_ready_n=0 in the first READ cycle.
- Hazard: channel i blocked while its word address matches any valid FIFO entry or a write being accepted this cycle. It waits until that entry has drained.
- Bypass: rd_chan_on[i]=0 -> rd_valid[i]=1, rd_data[i]=0, combinational. Channel never granted. If disabled while granted, the memory read completes, the response is dropped, and the FSM returns to IDLE.
- Write accept: wr_valid = wr_enable & (count<WBUF_DEPTH), combinational; push on wr_valid. wr_chan_on=0 -> wr_valid=1, nothing pushed.
- Drain: when non-empty, mem_write_n=0 with head address/data registered. Pop on mem_data_written_n=0; next entry is presented the following cycle. Push and pop in the same cycle leave count unchanged. Full with a pop in the same cycle does not accept; accepts next cycle.
- Read and write masters operate concurrently; ordering is guaranteed only via the hazard rule.

Test Plan:
- Single read ch0 addr 0x0000107, memory returns 0xDEADBEEF with ready_n low in 1st READ cycle -> mem_read_address=0x0000104, rd_valid[0] 3 cycles after enable with 0xDEADBEEF.
- ch0 and ch1 both continuously enabled -> grants alternate 0,1,0,1; neither starves; rd_valid never overlaps.
- 5 back-to-back writes with mem_data_written_n held high -> wr_valid high for first 4; wbuf_count=4; 5th stalls until first pop.
- Write 0x55 to 0x40 (buffer stalled), then read 0x42 on ch1 -> no mem_read_n until the write pops; the read then issues.
- rd_chan_on[1]=0, rd_enable[1]=1 -> rd_valid[1]=1, rd_data=0, no memory read; wr_chan_on=0 -> writes accepted, mem_write_n stays 1.
- reset asserted during READ and with 3 buffered writes -> next cycle mem_read_n=1, mem_write_n=1, wbuf_count=0; late ready_n pulse produces no rd_valid.

Source files
------------

// File: rtl/mem_bridge.sv
// mem_bridge: round-robin read arbiter and posted write FIFO between cores and one memory port
module mem_bridge #(
  parameter int NUM_READ   = 2,
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_READ-1:0]              rd_enable,
  input  logic [NUM_READ-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_READ-1:0]              rd_valid,
  output logic [NUM_READ-1:0][DATA_W-1:0]  rd_data,
  input  logic [NUM_READ-1:0]              rd_chan_on,
  input  logic                             wr_enable,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
  output logic                             wr_valid,
  input  logic                             wr_chan_on,
  output logic                             mem_read_n,
  output logic [ADDR_W-1:0]                mem_read_address,
  input  logic [DATA_W-1:0]                mem_read_data,
  input  logic                             mem_data_ready_n,
  output logic                             mem_write_n,
  output logic [ADDR_W-1:0]                mem_write_address,
  output logic [DATA_W-1:0]                mem_write_data,
  input  logic                             mem_data_written_n,
  output logic [$clog2(WBUF_DEPTH):0]      wbuf_count
);
  localparam int CW = $clog2(WBUF_DEPTH) + 1;
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int GW = NUM_READ > 1 ? $clog2(NUM_READ) : 1;
  localparam int WA = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t              r_state, w_next;
  logic [GW-1:0]       r_rr, r_grant, w_pick;
  logic                w_found;
  logic [WA-1:0]       r_raddr;
  logic [DATA_W-1:0]   r_rdata;
  logic [WA-1:0]       r_fa [WBUF_DEPTH];
  logic [DATA_W-1:0]   r_fd [WBUF_DEPTH];
  logic [PW-1:0]       r_wp, r_rp;
  logic [CW-1:0]       r_cnt;
  logic                w_push, w_pop, w_full, w_empty;
  logic [WBUF_DEPTH-1:0] w_live;
  logic [NUM_READ-1:0] w_hazard, w_cand;
  logic                w_unused;

  assign w_full     = r_cnt == CW'(WBUF_DEPTH);
  assign w_empty    = r_cnt == '0;
  assign wr_valid   = wr_enable & (~wr_chan_on | ~w_full);
  assign w_push     = wr_enable & wr_chan_on & ~w_full;
  assign w_pop      = ~w_empty & ~mem_data_written_n;
  assign wbuf_count = r_cnt;
  assign w_cand     = rd_enable & rd_chan_on & ~w_hazard;
  assign w_unused   = ^{wr_addr[1:0], rd_addr};

  // mark which FIFO slots hold an undrained write
  always_comb begin
    w_live = '0;
    for (int j = 0; j < WBUF_DEPTH; j++) w_live[j] = CW'(PW'(PW'(j) - r_rp)) < r_cnt;
  end

  // a channel may not read a word that still has a write queued or entering the queue
  always_comb begin
    w_hazard = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      for (int j = 0; j < WBUF_DEPTH; j++)
        if (w_live[j] && r_fa[j] == rd_addr[i][ADDR_W-1:2]) w_hazard[i] = 1'b1;
      if (w_push && wr_addr[ADDR_W-1:2] == rd_addr[i][ADDR_W-1:2]) w_hazard[i] = 1'b1;
    end
  end

  // round-robin pick: the nearest candidate after the last granted channel wins
  always_comb begin
    int d, best;
    w_found = 1'b0;
    w_pick  = r_rr;
    best    = NUM_READ;
    for (int i = 0; i < NUM_READ; i++) begin
      d = (i + NUM_READ - 1 - int'(r_rr)) % NUM_READ;
      if (w_cand[i] && d < best) begin
        best    = d;
        w_pick  = GW'(i);
        w_found = 1'b1;
      end
    end
  end

  // read FSM state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end

  // read FSM next state
  always_comb begin
    w_next = r_state == IDLE ? (w_found ? READ : IDLE) :
             r_state == READ ? (!mem_data_ready_n ? RESP : READ) : IDLE;
  end

  // grant, address and returned data latches
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr    <= GW'(NUM_READ - 1);
      r_grant <= '0;
      r_raddr <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == IDLE && w_found) begin
        r_rr    <= w_pick;
        r_grant <= w_pick;
        r_raddr <= rd_addr[w_pick][ADDR_W-1:2];
      end
      if (r_state == READ && !mem_data_ready_n) r_rdata <= mem_read_data;
    end
  end

  // read FSM outputs; disabled channels answer at once with zero data
  always_comb begin
    mem_read_n       = r_state != READ;
    mem_read_address = {r_raddr, 2'b00};
    rd_valid         = '0;
    rd_data          = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      rd_valid[i] = ~rd_chan_on[i] | (r_state == RESP && r_grant == GW'(i));
      rd_data[i]  = (rd_chan_on[i] && r_state == RESP && r_grant == GW'(i)) ? r_rdata : '0;
    end
  end

  // FIFO pointers and occupancy; reset discards whatever is queued
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop) r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fa[r_wp] <= wr_addr[ADDR_W-1:2];
      r_fd[r_wp] <= wr_data;
    end
  end

  // head of FIFO is presented to the memory write master whenever non-empty
  always_comb begin
    mem_write_n       = w_empty;
    mem_write_address = {r_fa[r_rp], 2'b00};
    mem_write_data    = r_fd[r_rp];
  end
endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed and randomized bench for mem_bridge against a queue/array reference model
module tb_mem_bridge;
  localparam int NR = 2, AW = 25, DW = 32, D = 4;

  logic clock = 1'b0, reset = 1'b1;
  logic [NR-1:0] rd_enable = '0, rd_valid, rd_chan_on = '1;
  logic [NR-1:0][AW-1:0] rd_addr = '0;
  logic [NR-1:0][DW-1:0] rd_data;
  logic wr_enable = 1'b0, wr_valid, wr_chan_on = 1'b1;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic mem_read_n, mem_data_ready_n = 1'b1, mem_write_n, mem_data_written_n = 1'b1;
  logic [AW-1:0] mem_read_address, mem_write_address;
  logic [DW-1:0] mem_read_data = '0, mem_write_data;
  logic [$clog2(D):0] wbuf_count;

  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;

  int checks = 0, failures = 0;
  int p_rd = 0, p_wr = 0;
  bit force_rdy = 1'b0;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] shadow [256];
  wr_t q[$];
  bit req [NR];
  int age [NR];

  always #5 clock = ~clock;

  mem_bridge #(.NUM_READ(NR), .ADDR_W(AW), .DATA_W(DW), .WBUF_DEPTH(D)) dut (
    .clock(clock), .reset(reset),
    .rd_enable(rd_enable), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_chan_on(rd_chan_on),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_chan_on(wr_chan_on),
    .mem_read_n(mem_read_n), .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
    .mem_data_ready_n(mem_data_ready_n),
    .mem_write_n(mem_write_n), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_data_written_n(mem_data_written_n),
    .wbuf_count(wbuf_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ix(input logic [AW-1:0] a);
    return a[9:2];
  endfunction

  task automatic clk_in();
    @(posedge clock);
    #2;
    mem_data_ready_n   = !(force_rdy || (!mem_read_n && $urandom_range(99) < p_rd));
    mem_read_data      = mem_data_ready_n ? $urandom : mem[ix(mem_read_address)];
    mem_data_written_n = !(!mem_write_n && $urandom_range(99) < p_wr);
  endtask

  task automatic settle();
    #1;
    if (reset) begin
      q.delete();
      shadow = mem;
      return;
    end
    check("wbuf_count", wbuf_count, q.size());
    check("mem_write_n", mem_write_n, q.size() == 0);
    if (wr_enable) check("wr_valid", wr_valid, !wr_chan_on || q.size() < D);
    if (!mem_read_n) check("rd_align", mem_read_address[1:0], 0);
    check("rd_overlap", $countones(rd_valid & rd_chan_on) <= 1, 1);
    for (int i = 0; i < NR; i++) begin
      if (!rd_chan_on[i]) begin
        check("bypass_valid", rd_valid[i], 1);
        check("bypass_data", rd_data[i], 0);
      end else if (rd_valid[i]) check("rd_data", rd_data[i], shadow[ix(rd_addr[i])]);
    end
    if (!mem_write_n && !mem_data_written_n && q.size() > 0) begin
      check("wr_mem_addr", mem_write_address, q[0].a);
      check("wr_mem_data", mem_write_data, q[0].d);
      mem[ix(q[0].a)] = q[0].d;
      void'(q.pop_front());
    end
    if (wr_enable && wr_valid && wr_chan_on) begin
      q.push_back(wr_t'{{wr_addr[AW-1:2], 2'b00}, wr_data});
      shadow[ix(wr_addr)] = wr_data;
    end
  endtask

  initial begin
    int exp_ch, n;
    bit got;
    logic [NR-1:0] done_v;
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    mem[8'h41] = 32'hDEADBEEF;
    shadow = mem;
    clk_in(); settle();
    clk_in(); settle();
    clk_in(); reset = 1'b0; settle();
    check("rst_read_n", mem_read_n, 1);
    check("rst_write_n", mem_write_n, 1);
    check("rst_count", wbuf_count, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);

    p_rd = 100;
    clk_in(); rd_addr[0] = 25'h107; rd_enable = 2'b01; settle();
    check("t1_c0_valid", rd_valid, 0);
    check("t1_c0_read_n", mem_read_n, 1);
    clk_in(); settle();
    check("t1_read_n", mem_read_n, 0);
    check("t1_addr", mem_read_address, 25'h104);
    clk_in(); settle();
    check("t1_valid", rd_valid, 2'b01);
    check("t1_data", rd_data[0], 32'hDEADBEEF);
    check("t1_read_n_up", mem_read_n, 1);
    clk_in(); rd_enable = 2'b00; settle();
    check("t1_one_shot", rd_valid, 0);

    rd_addr[0] = 25'h100;
    rd_addr[1] = 25'h204;
    exp_ch = 1;
    n = 0;
    for (int c = 0; c < 14; c++) begin
      clk_in(); rd_enable = 2'b11; settle();
      if (rd_valid != 0) begin
        check("rr_alt", rd_valid, 2'b01 << exp_ch);
        exp_ch ^= 1;
        n++;
      end
    end
    check("rr_count", n >= 4, 1);
    done_v = '0;
    for (int c = 0; c < 20 && rd_enable != 0; c++) begin
      clk_in(); rd_enable &= ~done_v; settle();
      done_v = rd_valid;
    end
    check("rr_wind_down", rd_enable, 0);

    p_wr = 0;
    for (int k = 0; k < 5; k++) begin
      clk_in(); wr_enable = 1'b1; wr_addr = AW'(32'h300 + 4 * k); wr_data = $urandom; settle();
      check("fill_accept", wr_valid, k < 4);
    end
    clk_in(); settle();
    check("full_count", wbuf_count, 4);
    check("full_stall", wr_valid, 0);
    check("full_head_n", mem_write_n, 0);
    check("full_head_addr", mem_write_address, 25'h300);
    p_wr = 100;
    clk_in(); settle();
    check("full_pop_stall", wr_valid, 0);
    p_wr = 0;
    clk_in(); settle();
    check("accept_after_pop", wr_valid, 1);
    check("count_after_pop", wbuf_count, 3);
    clk_in(); wr_enable = 1'b0; settle();
    check("count_refill", wbuf_count, 4);
    check("next_head_addr", mem_write_address, 25'h304);
    p_wr = 100;
    for (int c = 0; c < 20 && q.size() != 0; c++) begin clk_in(); settle(); end
    clk_in(); settle();
    check("drained", wbuf_count, 0);

    p_wr = 0;
    clk_in(); wr_enable = 1'b1; wr_addr = 25'h40; wr_data = 32'h55; settle();
    clk_in(); wr_enable = 1'b0; rd_addr[1] = 25'h42; rd_enable = 2'b10; settle();
    for (int c = 0; c < 5; c++) begin
      clk_in(); settle();
      check("hazard_block", mem_read_n, 1);
    end
    p_wr = 100;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      clk_in(); settle();
      if (rd_valid[1]) begin
        got = 1'b1;
        check("hazard_data", rd_data[1], 32'h55);
      end
    end
    check("hazard_done", got, 1);
    clk_in(); rd_enable = 2'b00; settle();

    for (int c = 0; c < 3; c++) begin
      clk_in(); rd_chan_on = 2'b01; rd_enable = 2'b10; settle();
      check("byp_valid", rd_valid[1], 1);
      check("byp_data", rd_data[1], 0);
      check("byp_no_read", mem_read_n, 1);
    end
    clk_in(); rd_enable = 2'b00; rd_chan_on = 2'b11; settle();
    for (int c = 0; c < 3; c++) begin
      clk_in(); wr_chan_on = 1'b0; wr_enable = 1'b1; wr_addr = AW'($urandom_range(1023)); wr_data = $urandom;
      settle();
      check("wdis_valid", wr_valid, 1);
      check("wdis_no_write", mem_write_n, 1);
      check("wdis_count", wbuf_count, 0);
    end
    clk_in(); wr_enable = 1'b0; wr_chan_on = 1'b1; settle();

    p_wr = 0;
    p_rd = 0;
    for (int k = 0; k < 3; k++) begin
      clk_in(); wr_enable = 1'b1; wr_addr = AW'(32'h380 + 4 * k); wr_data = $urandom; settle();
    end
    clk_in(); wr_enable = 1'b0; rd_addr[0] = 25'h0; rd_enable = 2'b01; settle();
    clk_in(); settle();
    check("pre_rst_read", mem_read_n, 0);
    check("pre_rst_count", wbuf_count, 3);
    clk_in(); reset = 1'b1; rd_enable = 2'b00; settle();
    clk_in(); reset = 1'b0; settle();
    check("mid_rst_read_n", mem_read_n, 1);
    check("mid_rst_write_n", mem_write_n, 1);
    check("mid_rst_count", wbuf_count, 0);
    force_rdy = 1'b1;
    clk_in(); force_rdy = 1'b0; settle();
    for (int c = 0; c < 3; c++) begin
      clk_in(); settle();
      check("late_ready_valid", rd_valid, 0);
      check("late_ready_read_n", mem_read_n, 1);
    end

    p_rd = 60;
    p_wr = 50;
    for (int i = 0; i < NR; i++) begin req[i] = 1'b0; age[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      clk_in();
      for (int i = 0; i < NR; i++) begin
        if (!req[i] && c < 2900 && $urandom_range(3) == 0) begin
          req[i] = 1'b1;
          age[i] = 0;
          rd_addr[i] = AW'($urandom_range(63));
        end
        rd_enable[i] = req[i];
      end
      wr_enable = c < 2900 && $urandom_range(2) == 0;
      wr_addr = AW'($urandom_range(63));
      wr_data = $urandom;
      for (int i = 0; i < NR; i++) if (req[i] && ix(rd_addr[i]) == ix(wr_addr)) wr_enable = 1'b0;
      settle();
      for (int i = 0; i < NR; i++) begin
        if (rd_valid[i]) begin
          check("rd_spurious", req[i], 1);
          req[i] = 1'b0;
        end else if (req[i] && ++age[i] > 300) begin
          check("rd_timeout", age[i], 0);
          req[i] = 1'b0;
        end
      end
    end
    p_rd = 100;
    p_wr = 100;
    for (int c = 0; c < 50 && q.size() != 0; c++) begin
      clk_in(); rd_enable = '0; wr_enable = 1'b0; settle();
    end
    check("final_drain", q.size(), 0);
    check("final_reqs", {req[0], req[1]}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
